// File: rtl/usart_tx_frame_if.sv
// Byte handshake between the parity generator stage and the USART transmit serializer.
// The master side offers a byte plus its parity bit; the slave side answers with ready.
interface usart_tx_frame_if;
    logic [7:0] tx_data;
    logic       parity_in;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output parity_in, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input parity_in, input tx_valid, output tx_ready);
endinterface

// File: rtl/usart_tx_frame.sv
// USART transmit serializer: start bit, 8 data bits LSB first, optional parity, stop bit(s).
// Optional parity slot is compiled in when USART_TX_PARITY_EN is defined.
module usart_tx_frame #(
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1
) (
    input  logic               clk,
    input  logic               rst,
    usart_tx_frame_if.slave    up,
    output logic               tx,
    output logic               tx_busy,
    output logic               tx_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic             STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef USART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic             stop_q, stop_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             done_q, done_d;
    logic             bit_end;
`ifdef USART_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    assign bit_end     = (cnt_q == CNT_LAST);
    assign up.tx_ready = (state_q == IDLE);
    assign tx_busy     = (state_q != IDLE);
    assign tx          = tx_q;
    assign tx_done     = done_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
`ifdef USART_TX_PARITY_EN
        par_d   = par_q;
`endif

        if (state_q != IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                // In IDLE ready is high, so valid alone means accept.
                if (up.tx_valid) begin
                    state_d = START;
                    shift_d = up.tx_data;
`ifdef USART_TX_PARITY_EN
                    par_d   = up.parity_in;
`endif
                    cnt_d   = '0;
                    bit_d   = '0;
                    stop_d  = 1'b0;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
`ifdef USART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = par_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
`ifdef USART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (stop_q == STOP_LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        stop_d  = 1'b1;
                    end
                    tx_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    // Frame payload holds no control meaning, so it is left out of reset.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
`ifdef USART_TX_PARITY_EN
        par_q   <= par_d;
`endif
    end

endmodule

// File: tb/tb_usart_tx_frame.sv
// Directed bench for usart_tx_frame with CLKS_PER_BIT=4; stop bits follow the parity build
// so every frame is 11 bit times (parity on: 1 stop bit, parity off: 2 stop bits).
module tb_usart_tx_frame;

    localparam int CPB = 4;
`ifdef USART_TX_PARITY_EN
    localparam int SB     = 1;
    localparam bit PAR_ON = 1'b1;
    localparam logic [10:0] EXP_A5 = 11'b1_0_10100101_0;
    localparam logic        P_A5   = 1'b0;
`else
    localparam int SB     = 2;
    localparam bit PAR_ON = 1'b0;
    localparam logic [10:0] EXP_A5 = 11'b1_1_10100101_0;
    localparam logic        P_A5   = 1'b1;
`endif
    localparam int FRAME_CYC = 11 * CPB;

    logic clk = 1'b0;
    logic rst;
    logic tx, tx_busy, tx_done;
    int   n_tests = 0;
    int   n_fail  = 0;

    usart_tx_frame_if intf ();

    usart_tx_frame #(.CLKS_PER_BIT(CPB), .STOP_BITS(SB)) dut (
        .clk     (clk),
        .rst     (rst),
        .up      (intf),
        .tx      (tx),
        .tx_busy (tx_busy),
        .tx_done (tx_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic p);
        return PAR_ON ? {1'b1, p, d, 1'b0} : {1'b1, 1'b1, d, 1'b0};
    endfunction

    task automatic check_idle(input string tag, input logic done_exp);
        check({tag, " tx"},    32'(tx),            32'd1);
        check({tag, " ready"}, 32'(intf.tx_ready), 32'd1);
        check({tag, " busy"},  32'(tx_busy),       32'd0);
        check({tag, " done"},  32'(tx_done),       32'(done_exp));
    endtask

    // Starts in a cycle where ready is high ("cycle 0") and returns in cycle 45.
    task automatic frame(input string tag, input logic [7:0] d, input logic p,
                         input logic [10:0] exp, input bit keep_valid,
                         input logic [7:0] next_d, input logic next_p, input bit corrupt);
        check({tag, " ready c0"}, 32'(intf.tx_ready), 32'd1);
        intf.tx_data   = d;
        intf.parity_in = p;
        intf.tx_valid  = 1'b1;
        for (int c = 1; c <= FRAME_CYC; c++) begin
            step();
            if (c == 1) begin
                if (keep_valid) begin
                    intf.tx_data   = next_d;
                    intf.parity_in = next_p;
                end else begin
                    intf.tx_valid = 1'b0;
                end
            end
            if (corrupt && c == 12) begin
                intf.tx_data   = 8'hFF;
                intf.parity_in = ~p;
            end
            check($sformatf("%s tx c%0d", tag, c), 32'(tx), 32'(exp[(c-1)/CPB]));
            check($sformatf("%s ready c%0d", tag, c), 32'(intf.tx_ready), 32'd0);
            check($sformatf("%s busy c%0d", tag, c), 32'(tx_busy), 32'd1);
            check($sformatf("%s done c%0d", tag, c), 32'(tx_done), 32'd0);
        end
        step();
        check_idle({tag, " end c45"}, 1'b1);
    endtask

    initial begin
        rst            = 1'b1;
        intf.tx_valid  = 1'b0;
        intf.tx_data   = 8'h00;
        intf.parity_in = 1'b0;

        for (int i = 0; i < 3; i++) begin
            step();
            check_idle($sformatf("reset %0d", i), 1'b0);
        end
        rst = 1'b0;
        step();
        check_idle("post reset", 1'b0);

        frame("a5", 8'hA5, P_A5, EXP_A5, 1'b0, 8'h00, 1'b0, 1'b0);
        step();
        check("a5 done clears", 32'(tx_done), 32'd0);

        frame("07", 8'h07, 1'b1, frame_bits(8'h07, 1'b1), 1'b0, 8'h00, 1'b0, 1'b1);

        frame("55", 8'h55, 1'b0, frame_bits(8'h55, 1'b0), 1'b1, 8'h3C, 1'b0, 1'b0);
        frame("3c", 8'h3C, 1'b0, frame_bits(8'h3C, 1'b0), 1'b0, 8'h00, 1'b0, 1'b0);
        step();

        // Abort during data bit 3 (cycles 17..20) of an 0xA5 frame.
        intf.tx_data   = 8'hA5;
        intf.parity_in = 1'b0;
        intf.tx_valid  = 1'b1;
        step();
        intf.tx_valid = 1'b0;
        check("abort start bit", 32'(tx), 32'd0);
        for (int c = 2; c <= 18; c++) step();
        check("abort d3 level", 32'(tx), 32'd0);
        check("abort busy", 32'(tx_busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("abort edge", 1'b0);
        for (int i = 0; i < 30; i++) begin
            step();
            check($sformatf("abort no done %0d", i), 32'(tx_done), 32'd0);
            check($sformatf("abort tx idle %0d", i), 32'(tx), 32'd1);
        end

        frame("81", 8'h81, 1'b0, frame_bits(8'h81, 1'b0), 1'b0, 8'h00, 1'b0, 1'b0);
        step();
        check_idle("final", 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/usart_tx_frame.md
Name: usart_tx_frame

Overview:
- Transmit serializer of the USART; sits directly downstream of the even-parity generator.
- Accepts a byte via valid/ready handshake and latches it with the parity bit computed by the generator from the same byte.
- Emits one asynchronous serial frame on `tx`: start bit, 8 data bits LSB first, optional parity bit, then stop bit(s).
- Baud timing comes from an internal clock-count divider.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per serial bit (100 MHz / 115200); legal range >= 2.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- tx_data  input  8  byte to transmit; sampled on accept
- parity_in  input  1  even parity of tx_data, driven by the parity generator; sampled on accept
- tx_valid  input  1  upstream has a byte
- tx_ready  output  1  block can accept a byte this cycle
- tx  output  1  serial line, registered, idle high
- tx_busy  output  1  frame in progress
- tx_done  output  1  one-cycle pulse at frame end

Behaviour:
- Reset (rst=1 at a clk edge, synchronous, active-high): tx=1, tx_ready=1, tx_busy=0, tx_done=0; state IDLE; baud counter and bit index cleared.
- Reset mid-frame: frame abandoned; tx=1 from the next edge; no tx_done.
- States and transitions:
  - IDLE → START on accept.
  - START → DATA.
  - DATA (8 bits) → PARITY (macro on) or STOP (macro off).
  - PARITY → STOP.
  - STOP (STOP_BITS bits) → IDLE.
- Accept: tx_valid && tx_ready at an edge. On that edge, latch tx_data and parity_in into a shift register and parity flop.
  - Later changes on tx_data or parity_in have no effect on the frame.
- tx_ready = 1 only in IDLE. tx_valid is ignored while busy. tx_busy = !tx_ready.
- Latency: tx goes 0 (start bit) on the cycle after accept.
- Bit timing: every bit holds exactly CLKS_PER_BIT cycles.
  - Baud counter width is $clog2(CLKS_PER_BIT); it counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
- Bit order and levels: data bit 0 first. Parity bit = latched parity_in. Stop bits = 1.
- Frame length: 1+8+P+STOP_BITS bit times (P=1 with the macro), e.g. 11 bit times for P=1, STOP_BITS=1.
- End of frame: at the end of the last stop bit, state returns to IDLE.
  - In that first IDLE cycle, tx_done=1 for exactly one cycle and tx_ready=1.
  - An accept in that same cycle starts the next frame with its start bit on the following cycle, so there are zero idle bit times between frames.
- tx stays at 1 throughout IDLE.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: USART_TX_PARITY_EN.
- Defined: PARITY state included; parity bit inserted between data bit 7 and the first stop bit.
- Undefined: PARITY state not compiled. Frame is 1+8+STOP_BITS bit times. The parity_in port remains present but is ignored.

Test Plan:
- Reset: hold rst=1 for 3 cycles → tx=1, tx_ready=1, tx_busy=0, tx_done=0 on the first edge after rst is asserted.
- CLKS_PER_BIT=4, STOP_BITS=1, macro defined; accept 0xA5 with parity_in=0 at cycle 0 →
  - tx low in cycles 1–4;
  - mid-bit samples 0,1,0,1,0,0,1,0,1,0,1;
  - tx_done=1 only in cycle 45; tx_ready=1 in cycle 45.
- Same config; accept 0x07 with parity_in=1 → parity slot (cycles 37–40) = 1. Change tx_data to 0xFF during the frame → serial data still 0x07.
- Back-to-back: tx_valid held high with 0x55 then 0x3C → second start bit begins in cycle 46 with no idle gap; tx_valid ignored in cycles 1–44.
- Reset mid-frame: assert rst during data bit 3 of 0xA5 → tx=1 and tx_ready=1 after that edge, no tx_done. A following 0x81 frame is bit-exact.
- Macro undefined, STOP_BITS=2, CLKS_PER_BIT=4; accept 0xA5 with parity_in=1 → 11 bit times: start, data, two stop bits, no parity slot; tx_done in cycle 45.
